// File: rtl/led_pwm_pkg.sv
// Shared encodings for the LED PWM controller: mode codes, breathe states and
// the duty ceiling helper.
package led_pwm_pkg;

    localparam logic [1:0] MODE_OFF     = 2'b00;
    localparam logic [1:0] MODE_FIXED   = 2'b01;
    localparam logic [1:0] MODE_BREATHE = 2'b10;

    typedef enum logic [1:0] {
        S_OFF   = 2'b00,
        S_FIXED = 2'b01,
        S_RISE  = 2'b10,
        S_FALL  = 2'b11
    } state_e;

    localparam int DEF_CNT_W = 8;

    function automatic int duty_max_f(input int cnt_w);
        return (1 << cnt_w) - 1;
    endfunction

    localparam int DUTY_MAX = duty_max_f(DEF_CNT_W);

endpackage

// File: rtl/led_fade_fsm.sv
// Duty sequencer: owns the active duty, the breathe ramp and the pending-write
// apply. Every change commits only on a period boundary.
//
//   state   | meaning
//   S_OFF   | LED dark, active duty forced to 0
//   S_FIXED | active duty held; a pending write is applied at the boundary
//   S_RISE  | duty climbs by FADE_STEP every STEP_PERIODS periods up to max
//   S_FALL  | duty drops by FADE_STEP every STEP_PERIODS periods down to 0
module led_fade_fsm
    import led_pwm_pkg::*;
#(
    parameter int CNT_W        = 8,
    parameter int STEP_PERIODS = 4,
    parameter int FADE_STEP    = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             boundary,
    input  logic [1:0]       mode,
    input  logic             pending,
    input  logic [CNT_W-1:0] pend_duty,
    output logic             apply,
    output logic             active,
    output logic [CNT_W-1:0] cur_duty
);

    localparam int             SW        = (STEP_PERIODS > 1) ? $clog2(STEP_PERIODS) : 1;
    localparam logic [SW-1:0]  STEP_LAST = SW'(STEP_PERIODS - 1);
    localparam logic [CNT_W:0] DMAX_W    = (CNT_W+1)'(duty_max_f(CNT_W));
    localparam logic [CNT_W:0] FADE_W    = (CNT_W+1)'(FADE_STEP);

    state_e           state_q, state_d;
    logic [SW-1:0]    step_q, step_d;
    logic [CNT_W-1:0] duty_q, duty_d;
    logic [CNT_W:0]   up_sum, dn_diff;
    logic             step_due;

    always_comb begin
        up_sum   = {1'b0, duty_q} + FADE_W;
        dn_diff  = {1'b0, duty_q} - FADE_W;
        step_due = (step_q == STEP_LAST);
        state_d  = state_q;
        step_d   = step_q;
        duty_d   = duty_q;
        apply    = 1'b0;
        if (boundary) begin
            case (mode)
                MODE_FIXED: begin
                    state_d = S_FIXED;
                    step_d  = '0;
                    if (pending) begin
                        duty_d = pend_duty;
                        apply  = 1'b1;
                    end
                end
                MODE_BREATHE: begin
                    if (state_q == S_RISE || state_q == S_FALL) begin
                        step_d = step_due ? '0 : step_q + SW'(1);
                        if (step_due && state_q == S_RISE) begin
                            // Extra carry bit lets the overshoot be seen and clamped.
                            if (up_sum >= DMAX_W) begin
                                duty_d  = DMAX_W[CNT_W-1:0];
                                state_d = S_FALL;
                            end else begin
                                duty_d = up_sum[CNT_W-1:0];
                            end
                        end else if (step_due) begin
                            if (dn_diff[CNT_W] || dn_diff == '0) begin
                                duty_d  = '0;
                                state_d = S_RISE;
                            end else begin
                                duty_d = dn_diff[CNT_W-1:0];
                            end
                        end
                    end else begin
                        state_d = S_RISE;
                        step_d  = '0;
                    end
                end
                default: begin
                    state_d = S_OFF;
                    step_d  = '0;
                    duty_d  = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= S_OFF;
            step_q  <= '0;
            duty_q  <= '0;
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
            duty_q  <= duty_d;
        end
    end

    assign active   = (state_q != S_OFF);
    assign cur_duty = duty_q;

endmodule

// File: rtl/led_pwm_ctrl.sv
// LED PWM controller: duty write handshake, counter compare and registered LED
// drive. Defining LED_PWM_PERIOD_TICK_EN adds the period_tick output.
module led_pwm_ctrl
    import led_pwm_pkg::*;
#(
    parameter int CNT_W        = 8,
    parameter int STEP_PERIODS = 4,
    parameter int FADE_STEP    = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [CNT_W-1:0] cnt,
    input  logic [1:0]       mode,
    input  logic [CNT_W-1:0] duty_in,
    input  logic             duty_valid,
    output logic             duty_ready,
    output logic [CNT_W-1:0] cur_duty,
    output logic             pwm_out
`ifdef LED_PWM_PERIOD_TICK_EN
    ,
    output logic             period_tick
`endif
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(duty_max_f(CNT_W));

    logic             pending_q, pending_d;
    logic [CNT_W-1:0] pend_duty_q, pend_duty_d;
    logic             pwm_q, pwm_d;
    logic             boundary, accept, apply, active;

    assign boundary = (cnt == CNT_MAX);
    assign accept   = duty_valid && !pending_q;

    led_fade_fsm #(
        .CNT_W        (CNT_W),
        .STEP_PERIODS (STEP_PERIODS),
        .FADE_STEP    (FADE_STEP)
    ) u_fsm (
        .clk       (clk),
        .rst       (rst),
        .boundary  (boundary),
        .mode      (mode),
        .pending   (pending_q),
        .pend_duty (pend_duty_q),
        .apply     (apply),
        .active    (active),
        .cur_duty  (cur_duty)
    );

    // apply and accept never coincide: accept needs pending_q low, apply needs it high.
    always_comb begin
        pending_d   = pending_q;
        pend_duty_d = pend_duty_q;
        pwm_d       = active && (cnt < cur_duty);
        if (apply) begin
            pending_d = 1'b0;
        end else if (accept) begin
            pending_d   = 1'b1;
            pend_duty_d = duty_in;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            pending_q   <= 1'b0;
            pend_duty_q <= '0;
            pwm_q       <= 1'b0;
        end else begin
            pending_q   <= pending_d;
            pend_duty_q <= pend_duty_d;
            pwm_q       <= pwm_d;
        end
    end

    assign duty_ready = !pending_q;
    assign pwm_out    = pwm_q;

`ifdef LED_PWM_PERIOD_TICK_EN
    logic tick_q, tick_d;

    always_comb begin
        tick_d = boundary;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            tick_q <= 1'b0;
        end else begin
            tick_q <= tick_d;
        end
    end

    assign period_tick = tick_q;
`endif

endmodule
